// File: rtl/seg_pkg.sv
// Constants shared by the 7-segment display controller, the scan driver and its bench.
package seg_pkg;

   localparam int unsigned NUM_DIGITS = 4;
   localparam int unsigned IDX_W      = 2;
   localparam int unsigned SEG_W      = 8;
   localparam int unsigned AN_W       = 4;

   localparam logic [SEG_W-1:0] SEG_BLANK = 8'hFF;
   localparam logic [AN_W-1:0]  AN_OFF    = 4'b1111;

   // "LOSE" glyphs, active-low segments, DP off
   localparam logic [SEG_W-1:0] GLYPH_L = 8'hC7;
   localparam logic [SEG_W-1:0] GLYPH_O = 8'hC0;
   localparam logic [SEG_W-1:0] GLYPH_S = 8'h92;
   localparam logic [SEG_W-1:0] GLYPH_E = 8'h86;

   // Active-low anode pattern for a slot; slot 0 is the leftmost digit (an[3]).
   function automatic logic [AN_W-1:0] an_for_idx(input logic [IDX_W-1:0] idx);
      return ~(4'b1000 >> idx);
   endfunction

endpackage

// File: rtl/seg_slot_timer.sv
// Digit-slot timebase: tracks (idx, cnt) and exposes next-state and strobe signals.
module seg_slot_timer
   import seg_pkg::*;
#(
   parameter int unsigned DIGIT_CYCLES = 100000,
   parameter int unsigned BLANK_CYCLES = 1000
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_enable,
   output logic [IDX_W-1:0] o_idx_nxt_c,
   output logic             o_blank_nxt_c,
   output logic             o_slot_end_c,
   output logic             o_frame_wrap_c
);

   localparam int unsigned          CNT_W     = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
   localparam logic [CNT_W-1:0]     CNT_LAST  = CNT_W'(DIGIT_CYCLES - 1);
   localparam logic [CNT_W-1:0]     BLANK_LIM = CNT_W'(BLANK_CYCLES);
   localparam logic [IDX_W-1:0]     IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

   logic [CNT_W-1:0] r_cnt;
   logic [IDX_W-1:0] r_idx;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [IDX_W-1:0] w_idx_nxt;
   logic             w_slot_end;

   // Next (idx, cnt); disabled parks on the last cycle of slot 3 so re-enable starts a frame
   always_comb begin
      w_slot_end = (r_cnt == CNT_LAST);
      w_cnt_nxt  = r_cnt + CNT_W'(1);
      w_idx_nxt  = r_idx;
      if (!i_enable) begin
         w_cnt_nxt = CNT_LAST;
         w_idx_nxt = IDX_LAST;
      end else if (w_slot_end) begin
         w_cnt_nxt = '0;
         w_idx_nxt = r_idx + IDX_W'(1);
      end
   end

   // Slot position registers; reset parks exactly as a disable does
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= CNT_LAST;
         r_idx <= IDX_LAST;
      end else begin
         r_cnt <= w_cnt_nxt;
         r_idx <= w_idx_nxt;
      end
   end

   assign o_idx_nxt_c    = w_idx_nxt;
   assign o_blank_nxt_c  = (w_cnt_nxt < BLANK_LIM);
   assign o_slot_end_c   = i_enable & w_slot_end;
   assign o_frame_wrap_c = o_slot_end_c & (r_idx == IDX_LAST);

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexes four segment bytes onto a common-anode 4-digit display with
// per-slot blanking and a once-per-frame input snapshot.
module seg_scan_driver
   import seg_pkg::*;
#(
   parameter int unsigned DIGIT_CYCLES = 100000,
   parameter int unsigned BLANK_CYCLES = 1000
) (
   input  logic             Clk100M,
   input  logic             rstN,
   input  logic             enable,
   input  logic [SEG_W-1:0] segIn0,
   input  logic [SEG_W-1:0] segIn1,
   input  logic [SEG_W-1:0] segIn2,
   input  logic [SEG_W-1:0] segIn3,
   output logic [AN_W-1:0]  an,
   output logic [SEG_W-1:0] seg,
   output logic             frameStart
);

   logic [SEG_W-1:0] w_seg_in [NUM_DIGITS];
   logic [SEG_W-1:0] r_snap   [NUM_DIGITS];
   logic [AN_W-1:0]  r_an;
   logic [SEG_W-1:0] r_seg;
   logic             r_frame_start;

   logic [IDX_W-1:0] w_idx_nxt;
   logic             w_blank_nxt;
   logic             w_slot_end;
   logic             w_frame_wrap;

   assign w_seg_in[0] = segIn0;
   assign w_seg_in[1] = segIn1;
   assign w_seg_in[2] = segIn2;
   assign w_seg_in[3] = segIn3;

   seg_slot_timer #(
      .DIGIT_CYCLES (DIGIT_CYCLES),
      .BLANK_CYCLES (BLANK_CYCLES)
   ) u_timer (
      .i_clk          (Clk100M),
      .i_rst_n        (rstN),
      .i_enable       (enable),
      .o_idx_nxt_c    (w_idx_nxt),
      .o_blank_nxt_c  (w_blank_nxt),
      .o_slot_end_c   (w_slot_end),
      .o_frame_wrap_c (w_frame_wrap)
   );

   // Capture all four digits together at the frame boundary so a frame never tears
   always_ff @(posedge Clk100M or negedge rstN) begin
      if (!rstN) begin
         for (int i = 0; i < NUM_DIGITS; i++) r_snap[i] <= SEG_BLANK;
      end else if (w_frame_wrap) begin
         for (int i = 0; i < NUM_DIGITS; i++) r_snap[i] <= w_seg_in[i];
      end
   end

   // Registered drive for the slot position being entered; the first cycle of every
   // slot is blank, so the snapshot loaded on the same edge is never needed yet
   always_ff @(posedge Clk100M or negedge rstN) begin
      if (!rstN) begin
         r_an          <= AN_OFF;
         r_seg         <= SEG_BLANK;
         r_frame_start <= 1'b0;
      end else if (!enable) begin
         r_an          <= AN_OFF;
         r_seg         <= SEG_BLANK;
         r_frame_start <= 1'b0;
      end else begin
         r_frame_start <= w_frame_wrap;
         if (w_blank_nxt) begin
            r_an  <= AN_OFF;
            r_seg <= SEG_BLANK;
         end else begin
            r_an  <= an_for_idx(w_idx_nxt);
            r_seg <= r_snap[w_idx_nxt];
         end
      end
   end

   assign an         = r_an;
   assign seg        = r_seg;
   assign frameStart = r_frame_start;

   logic w_unused;
   assign w_unused = w_slot_end;

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
- Downstream of the display controller: consumes its four registered 8-bit segment bytes and time-multiplexes them onto one shared 4-digit, common-anode 7-segment display.
- Drives the active-low anode enables and the active-low cathode byte (7 segments + DP).
- Inserts a blanking interval at each digit switch to suppress ghosting.
- Snapshots all four inputs once per frame so the display never tears mid-frame.

Parameters:
- DIGIT_CYCLES, 100000, Clk100M cycles per digit slot (1 ms at 100 MHz; 4 ms frame). Must be >= 2.
- BLANK_CYCLES, 1000, cycles at the start of each slot with all anodes off. Must be >= 1 and < DIGIT_CYCLES.

Ports:
- Clk100M  input  1  system clock, 100 MHz
- rstN  input  1  asynchronous active-low reset
- enable  input  1  scan enable; low forces the display dark
- segIn0  input  8  leftmost digit pattern, active-low segments, bit7 = DP
- segIn1  input  8  second digit pattern
- segIn2  input  8  third digit pattern
- segIn3  input  8  rightmost digit pattern
- an  output  4  anode enables, active-low; an[3] = leftmost
- seg  output  8  cathode byte, active-low, bit7 = DP
- frameStart  output  1  one-cycle pulse on the first cycle of each frame

Behaviour:
- Reset (rstN low, asynchronous, all flops):
  - an = 4'b1111, seg = 8'hFF, frameStart = 0.
  - Snapshot registers = 8'hFF.
  - Internal slot index = 3, slot counter = DIGIT_CYCLES-1, so the first edge after release starts a frame.
- State per cycle is the pair (idx 0..3, cnt 0..DIGIT_CYCLES-1). On each edge with enable high:
  - cnt increments.
  - At cnt = DIGIT_CYCLES-1, cnt wraps to 0 and idx increments, wrapping from 3 to 0.
- Frame start: on the edge where idx wraps 3->0:
  - snap0..3 load segIn0..3.
  - frameStart is 1 for exactly that new cycle (idx = 0, cnt = 0), else 0.
  - Inputs are sampled only at this edge; changes elsewhere are invisible until the next frame.
- Outputs are registered and aligned with the (idx, cnt) they represent:
  - cnt < BLANK_CYCLES: an = 4'b1111, seg = 8'hFF (BLANK phase).
  - cnt >= BLANK_CYCLES: an has only bit (3-idx) low, seg = snap[idx] (DRIVE phase).
- Mapping: idx 0 -> an = 4'b0111 / snap0; idx 1 -> 4'b1011 / snap1; idx 2 -> 4'b1101 / snap2; idx 3 -> 4'b1110 / snap3.
- Never more than one anode low in any cycle, including the cycles around a transition.
- enable low (synchronous):
  - Next edge forces an = 4'b1111, seg = 8'hFF, frameStart = 0.
  - idx = 3, cnt = DIGIT_CYCLES-1; snapshots are held.
  - On the first edge with enable high again, a new frame starts exactly as after reset: snapshot load and a frameStart pulse.
- Reset asserted mid-slot: outputs go dark immediately, without waiting for a clock edge.
- Counter width: $clog2(DIGIT_CYCLES). Compare against DIGIT_CYCLES-1 so there is no overflow and no dependence on power-of-two values.
- A segIn value that changes on the same edge as the snapshot is captured with its pre-edge value.

Decomposition:
- Shared package seg_pkg holds:
  - NUM_DIGITS = 4
  - SEG_BLANK = 8'hFF
  - AN_OFF = 4'b1111
  - the LOSE glyph constants (L 8'hC7, O 8'hC0, S 8'h92, E 8'h86), so the display controller and bench share them.
- One sub-module, seg_slot_timer: holds cnt/idx and produces the slotEnd, frameWrap and inBlank strobes. seg_scan_driver keeps the snapshot registers and output registers.

Test Plan:
- Reset release with DIGIT_CYCLES=8, BLANK_CYCLES=2, enable=1, segIn = C7,C0,92,86 -> frameStart pulse on first cycle. Then, per slot: 2 cycles an=1111/seg=FF, then 6 cycles an=0111 seg=C7, next slot an=1011 seg=C0, then an=1101 seg=92, then an=1110 seg=86. Frame period 32 cycles.
- Change segIn0 to 8'h40 during slot 1 -> current frame still shows C7 on an=0111; next frame shows 40. frameStart pulses every 32 cycles.
- Assert checker every cycle across 10 frames -> an has at most one zero bit; seg = FF whenever an = 1111.
- Drop enable for 5 cycles mid-slot 2 -> an=1111, seg=FF from the next edge. After re-enable: frameStart pulse, an=1111 for 2 cycles, then an=0111 with the freshly sampled segIn0.
- Pulse rstN low asynchronously (between edges) during DRIVE of slot 3 -> an=1111, seg=FF, frameStart=0 immediately. Restart identical to the first scenario.
- Boundary DIGIT_CYCLES=2, BLANK_CYCLES=1 -> alternating blank/drive cycles; digit order 0,1,2,3 repeats every 8 cycles.
